tie_net_monitor: RTL and testbench



---
 rtl/tie_net_monitor.sv | 153 +++++++++++++++
 tb/tb_tie_net_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tie_net_monitor.sv
// Tie-high / tie-low net monitor: synchronizes both tie nets, filters
// glitches with a consecutive-violation run counter, and raises sticky faults.
module tie_net_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int THRESH      = 4,
  parameter int CNT_W       = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             one,
  input  logic             zero,
  input  logic             clr,
  output logic             fault_one,
  output logic             fault_zero,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(THRESH + 1);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_SUS = 2'd1;
  localparam logic [1:0] ST_FLT = 2'd2;

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] one_sync_q;
  logic [SYNC_STAGES-1:0] one_sync_d;
  logic [SYNC_STAGES-1:0] zero_sync_q;
  logic [SYNC_STAGES-1:0] zero_sync_d;

  logic       s_one;
  logic       s_zero;
  logic [1:0] viol;

  // index 0 tracks the tie-high net, index 1 the tie-low net
  logic [1:0][1:0]       st_q;
  logic [1:0][1:0]       st_d;
  logic [1:0][RUN_W-1:0] run_q;
  logic [1:0][RUN_W-1:0] run_d;
  logic [1:0]            enter;

  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W+1:0] err_sum;

  // shift each raw tie net through its synchronizer chain
  always_comb begin
    one_sync_d     = one_sync_q;
    zero_sync_d    = zero_sync_q;
    one_sync_d[0]  = one;
    zero_sync_d[0] = zero;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      one_sync_d[i]  = one_sync_q[i-1];
      zero_sync_d[i] = zero_sync_q[i-1];
    end
  end

  assign s_one  = one_sync_q[SYNC_STAGES-1];
  assign s_zero = zero_sync_q[SYNC_STAGES-1];

  // anything other than a clean expected level (including X/Z) is a violation
  assign viol[0] = (s_one !== 1'b1);
  assign viol[1] = (s_zero !== 1'b0);

  // per-net glitch filter: OK -> SUSPECT -> FAULT, clr overrides entry
  always_comb begin
    st_d  = st_q;
    run_d = run_q;
    enter = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (clr) begin
        st_d[n]  = ST_OK;
        run_d[n] = '0;
      end else begin
        case (st_q[n])
          ST_OK: begin
            if (viol[n]) begin
              if (THRESH == 1) begin
                st_d[n]  = ST_FLT;
                run_d[n] = '0;
                enter[n] = 1'b1;
              end else begin
                st_d[n]  = ST_SUS;
                run_d[n] = RUN_W'(1);
              end
            end
          end
          ST_SUS: begin
            if (viol[n]) begin
              if (run_q[n] == RUN_LAST) begin
                st_d[n]  = ST_FLT;
                run_d[n] = '0;
                enter[n] = 1'b1;
              end else begin
                run_d[n] = run_q[n] + RUN_W'(1);
              end
            end else begin
              st_d[n]  = ST_OK;
              run_d[n] = '0;
            end
          end
          ST_FLT: begin
            st_d[n]  = ST_FLT;
            run_d[n] = '0;
          end
          default: begin
            st_d[n]  = ST_OK;
            run_d[n] = '0;
          end
        endcase
      end
    end
  end

  // saturating count of fault entries; simultaneous entries add two
  always_comb begin
    err_sum = {2'b00, err_cnt_q}
            + (CNT_W+2)'(enter[0])
            + (CNT_W+2)'(enter[1]);
    if (clr) begin
      err_cnt_d = '0;
    end else if (err_sum > {2'b00, CNT_MAX}) begin
      err_cnt_d = CNT_MAX;
    end else begin
      err_cnt_d = err_sum[CNT_W-1:0];
    end
  end

  // state registers; reset parks synchronizers at the safe tie levels
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      one_sync_q  <= '1;
      zero_sync_q <= '0;
      st_q        <= {ST_OK, ST_OK};
      run_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      one_sync_q  <= one_sync_d;
      zero_sync_q <= zero_sync_d;
      st_q        <= st_d;
      run_q       <= run_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign fault_one  = (st_q[0] == ST_FLT);
  assign fault_zero = (st_q[1] == ST_FLT);
  assign fault      = fault_one | fault_zero;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tie_net_monitor.sv
// Bench for tie_net_monitor: default instance driven from a vector table,
// plus saturation (CNT_W=1) and fast-filter (THRESH=1, SYNC_STAGES=1) instances.
module tb_tie_net_monitor;

  logic ck;
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // default instance
  logic d_rst, d_one, d_zero, d_clr;
  logic d_f1, d_f0, d_f;
  logic [7:0] d_cnt;

  // saturation instance
  logic s_rst, s_one, s_zero, s_clr;
  logic s_f1, s_f0, s_f;
  logic [0:0] s_cnt;

  // THRESH=1, SYNC_STAGES=1 instance
  logic t_rst, t_one, t_zero, t_clr;
  logic t_f1, t_f0, t_f;
  logic [7:0] t_cnt;

  tie_net_monitor u_dut (
    .ck(ck), .rst(d_rst), .one(d_one), .zero(d_zero), .clr(d_clr),
    .fault_one(d_f1), .fault_zero(d_f0), .fault(d_f), .err_cnt(d_cnt)
  );

  tie_net_monitor #(.SYNC_STAGES(2), .THRESH(4), .CNT_W(1)) u_sat (
    .ck(ck), .rst(s_rst), .one(s_one), .zero(s_zero), .clr(s_clr),
    .fault_one(s_f1), .fault_zero(s_f0), .fault(s_f), .err_cnt(s_cnt)
  );

  tie_net_monitor #(.SYNC_STAGES(1), .THRESH(1), .CNT_W(8)) u_t1 (
    .ck(ck), .rst(t_rst), .one(t_one), .zero(t_zero), .clr(t_clr),
    .fault_one(t_f1), .fault_zero(t_f0), .fault(t_f), .err_cnt(t_cnt)
  );

  typedef struct {
    logic one;
    logic zero;
    logic clr;
    logic f1;
    logic f0;
    int   cnt;
  } vec_t;

  vec_t tbl[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic add(input logic o, input logic z, input logic c,
                     input logic f1, input logic f0, input int cnt,
                     input int reps);
    vec_t v;
    v.one = o; v.zero = z; v.clr = c;
    v.f1 = f1; v.f0 = f0; v.cnt = cnt;
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  initial begin
    // glitch of 3 samples, then clean
    add(0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 5);
    // held violation on one: fault after the 6th edge
    add(0, 0, 0, 0, 0, 0, 5);
    add(0, 0, 0, 1, 0, 1, 1);
    add(1, 0, 0, 1, 0, 1, 3);
    // clear, then both nets bad together
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 1, 1, 2, 2);
    // clr pulse with inputs still bad, then re-fault 4 edges later
    add(0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 3);
    add(0, 1, 0, 1, 1, 2, 1);
    // clr held high, then clean inputs with stale synchronizer
    add(0, 1, 1, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 5);
  end

  initial begin
    d_rst = 1; d_one = 1; d_zero = 0; d_clr = 0;
    s_rst = 1; s_one = 1; s_zero = 0; s_clr = 0;
    t_rst = 1; t_one = 1; t_zero = 0; t_clr = 0;
    #1;
    chk("rst d", {d_f1, d_f0, d_f, d_cnt}, 0);
    chk("rst s", {s_f1, s_f0, s_f, s_cnt}, 0);
    chk("rst t", {t_f1, t_f0, t_f, t_cnt}, 0);
    tick();
    tick();
    d_rst = 0; s_rst = 0; t_rst = 0;

    // idle: nets at their tie levels
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("idle%0d", i), {d_f1, d_f0, d_f, d_cnt}, 0);
    end

    // vector table on default instance
    for (int i = 0; i < tbl.size(); i++) begin
      d_one = tbl[i].one; d_zero = tbl[i].zero; d_clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d f1", i), d_f1, tbl[i].f1);
      chk($sformatf("vec%0d f0", i), d_f0, tbl[i].f0);
      chk($sformatf("vec%0d f", i), d_f, tbl[i].f1 | tbl[i].f0);
      chk($sformatf("vec%0d cnt", i), d_cnt, tbl[i].cnt);
    end

    // async reset while zero filter sits at run=3 and one is faulted
    d_one = 0; d_zero = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("ar f1 pre", d_f1, 1);
    chk("ar cnt pre", d_cnt, 1);
    d_zero = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("ar f0 sus", d_f0, 0);
    #2;
    d_rst = 1;
    #1;
    chk("ar f1", d_f1, 0);
    chk("ar f0", d_f0, 0);
    chk("ar f", d_f, 0);
    chk("ar cnt", d_cnt, 0);
    d_one = 1; d_zero = 0;
    tick();
    d_rst = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("ar post", {d_f1, d_f0, d_f, d_cnt}, 0);

    // saturation with CNT_W=1: double entry from 0 ends at 1
    s_one = 0; s_zero = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("sat pre", {s_f1, s_f0, s_cnt}, 0);
    tick();
    chk("sat both", {s_f1, s_f0, s_f}, 7);
    chk("sat dbl", s_cnt, 1);
    s_one = 1; s_zero = 0; s_clr = 1;
    tick();
    s_clr = 0;
    chk("sat clr", {s_f1, s_f0, s_cnt}, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("sat idle", {s_f1, s_f0, s_cnt}, 0);
    s_one = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("sat f1", s_f1, 1);
    chk("sat cnt1", s_cnt, 1);
    s_zero = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat f0", s_f0, 1);
    chk("sat hold", s_cnt, 1);

    // THRESH=1, SYNC_STAGES=1: single-cycle pulse faults after 2 edges
    t_zero = 1;
    tick();
    chk("t1 e1", t_f0, 0);
    t_zero = 0;
    tick();
    chk("t1 e2", t_f0, 1);
    chk("t1 cnt", t_cnt, 1);
    t_clr = 1;
    tick();
    chk("t1 clr", {t_f0, t_cnt}, 0);
    t_clr = 0;
    t_zero = 1;
    tick();
    t_zero = 0; t_clr = 1;
    tick();
    chk("t1 sup f0", t_f0, 0);
    chk("t1 sup cnt", t_cnt, 0);
    t_clr = 0;
    tick();
    chk("t1 after", {t_f1, t_f0, t_f, t_cnt}, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
